obi_mem_arbiter: RTL and testbench

- Shares one OBI-style memory port between the core's instruction-fetch port and its data port; it is the 2:1 arbiter in front of a single-ported unified memory.
- Sits between the core's instr_*/data_* interfaces and the memory.
- Locks the selected requester until the memory grants it, so the address phase stays stable.
- Tracks outstanding transactions in an in-order ID FIFO and steers each rvalid back to the requester that issued it.

---
 rtl/obi_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: 2:1 OBI arbiter sharing one memory port between the
// instruction-fetch and data ports of a core. The selected requester is held
// until granted so the address phase stays stable. An in-order ID FIFO
// records which port issued each granted transaction, and each rvalid is
// steered back to that port.
// Build option: define OBI_MEM_ARBITER_RR_EN for round-robin arbitration on
// simultaneous requests. Without it, data has fixed priority over instr.
module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction fetch port
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic [6:0]  instr_rdata_intg_o,
    output logic        instr_err_o,
    // data port
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [6:0]  data_wdata_intg_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,
    // shared memory port
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [6:0]  mem_wdata_intg_o,
    input  logic [31:0] mem_rdata_i,
    input  logic [6:0]  mem_rdata_intg_i,
    input  logic        mem_err_i,
    // sticky protocol error flag
    output logic        err_unexp_rvalid_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // The port ID is 1 bit: 0 = instr, 1 = data.
    logic [0:0]       state_reg, state_next;
    logic             owner_reg, owner_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic             id_mem [MAX_OUTSTANDING];

    logic             full;
    logic             empty;
    logic             winner;
    logic             sel;
    logic             req_sel;
    logic             push;
    logic             pop;
    logic             head_id;
    logic             err_unexp_reg;

`ifdef OBI_MEM_ARBITER_RR_EN
    // last_reg = 1 means data was granted last. It resets to 0 so that data
    // wins the first tie.
    logic last_reg;

    // Round-robin choice: on a tie, the port not granted last wins.
    always_comb begin
        if (instr_req_i && data_req_i) begin
            winner = ~last_reg;
        end else begin
            winner = data_req_i | ~instr_req_i;
        end
    end

    // Record the port of every pushed grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_reg <= 1'b0;
        end else if (push) begin
            last_reg <= sel;
        end
    end
`else
    // Fixed priority: data beats instr. With no request, data is selected so
    // that the idle mem_* outputs carry the data port's values.
    always_comb begin
        winner = data_req_i | ~instr_req_i;
    end
`endif

    // Select the port. The owner is held while LOCKED. In IDLE, nothing is
    // requested when the ID FIFO is full.
    always_comb begin
        full    = (count_reg == CNT_MAX);
        empty   = (count_reg == '0);
        sel     = 1'b1;
        req_sel = 1'b0;
        if (state_reg == LOCKED) begin
            sel     = owner_reg;
            req_sel = owner_reg ? data_req_i : instr_req_i;
        end else if (!full) begin
            sel     = winner;
            req_sel = instr_req_i | data_req_i;
        end
    end

    assign mem_req_o = req_sel & ~rst_i;
    assign push      = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~empty & ~rst_i;
    assign head_id   = id_mem[rd_ptr_reg];

    // Grants pass straight through from the memory with no added latency.
    assign instr_gnt_o    = push & ~sel;
    assign data_gnt_o     = push & sel;
    assign instr_rvalid_o = pop & ~head_id;
    assign data_rvalid_o  = pop & head_id;

    // Address-phase mux. A fetch is always a full-word read.
    assign mem_we_o         = sel ? data_we_i         : 1'b0;
    assign mem_be_o         = sel ? data_be_i         : 4'hF;
    assign mem_addr_o       = sel ? data_addr_i       : instr_addr_i;
    assign mem_wdata_o      = sel ? data_wdata_i      : 32'h0;
    assign mem_wdata_intg_o = sel ? data_wdata_intg_i : 7'h0;

    // The response payload is broadcast to both ports. Only rvalid is steered.
    assign instr_rdata_o      = mem_rdata_i;
    assign instr_rdata_intg_o = mem_rdata_intg_i;
    assign instr_err_o        = mem_err_i;
    assign data_rdata_o       = mem_rdata_i;
    assign data_rdata_intg_o  = mem_rdata_intg_i;
    assign data_err_o         = mem_err_i;

    assign err_unexp_rvalid_o = err_unexp_reg;

    // Next-state logic for the lock FSM and the outstanding counter.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_sel && !mem_gnt_i) begin
                    state_next = LOCKED;
                    owner_next = sel;
                end
            end
            LOCKED: begin
                // Leave LOCKED on a grant, or if the owner drops its request.
                if (!req_sel || mem_gnt_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        unique case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // State, counter, FIFO pointers and the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            err_unexp_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (mem_rvalid_i && empty) begin
                err_unexp_reg <= 1'b1;
            end
        end
    end

    // ID FIFO storage. Stale entries are never read, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= sel;
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed steps followed by a randomized phase. Every
// cycle is checked against a queue-based reference model of the arbiter.
module tb_obi_mem_arbiter;

    localparam int MAX = 2;
`ifdef OBI_MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic [6:0]  instr_rdata_intg_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [6:0]  data_wdata_intg_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic [6:0]  data_rdata_intg_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [6:0]  mem_wdata_intg_o, mem_rdata_intg_i;
    logic        err_unexp_rvalid_o;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_rdata_intg_o(instr_rdata_intg_o),
        .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_wdata_intg_i(data_wdata_intg_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_rdata_intg_o(data_rdata_intg_o),
        .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wdata_intg_o(mem_wdata_intg_o),
        .mem_rdata_i(mem_rdata_i), .mem_rdata_intg_i(mem_rdata_intg_i),
        .mem_err_i(mem_err_i),
        .err_unexp_rvalid_o(err_unexp_rvalid_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: lock_owner is -1 when no port is locked, otherwise
    // 0 (instr) or 1 (data). idq holds the ports of the outstanding
    // transactions, oldest first.
    int lock_owner = -1;
    int idq[$];
    bit sticky     = 1'b0;
    int last_port  = 0;

    // Expectations for the current cycle.
    bit e_req, e_ig, e_dg, e_ir, e_dr;
    int e_sel;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Works out the expected outputs from the model state and current inputs.
    function automatic void model_eval();
        e_req = 1'b0; e_ig = 1'b0; e_dg = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_sel = 1;
        if (rst_i) return;
        if (lock_owner >= 0) begin
            e_sel = lock_owner;
            e_req = (lock_owner == 1) ? data_req_i : instr_req_i;
        end else if (idq.size() < MAX) begin
            e_req = instr_req_i | data_req_i;
            if (instr_req_i && data_req_i) e_sel = RR ? (1 - last_port) : 1;
            else e_sel = data_req_i ? 1 : (instr_req_i ? 0 : 1);
        end
        e_ig = e_req && mem_gnt_i && (e_sel == 0);
        e_dg = e_req && mem_gnt_i && (e_sel == 1);
        if (mem_rvalid_i && idq.size() > 0) begin
            e_ir = (idq[0] == 0);
            e_dr = (idq[0] == 1);
        end
    endfunction

    // Advances the model across one clock edge.
    function automatic void model_update();
        if (rst_i) begin
            lock_owner = -1; idq.delete(); sticky = 1'b0; last_port = 0;
            return;
        end
        if (mem_rvalid_i) begin
            if (idq.size() > 0) idq.delete(0);
            else sticky = 1'b1;
        end
        if (e_req && mem_gnt_i) begin
            idq.push_back(e_sel);
            last_port  = e_sel;
            lock_owner = -1;
        end else if (e_req && lock_owner < 0) begin
            lock_owner = e_sel;
        end else if (!e_req && lock_owner >= 0) begin
            lock_owner = -1;
        end
    endfunction

    // One clock: check the outputs at the falling edge, then step the model at
    // the rising edge. Inputs change 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk_i);
        model_eval();
        chk("mem_req", mem_req_o, e_req);
        chk("instr_gnt", instr_gnt_o, e_ig);
        chk("data_gnt", data_gnt_o, e_dg);
        chk("instr_rvalid", instr_rvalid_o, e_ir);
        chk("data_rvalid", data_rvalid_o, e_dr);
        chk("err_unexp", err_unexp_rvalid_o, sticky);
        chk("instr_resp", {instr_err_o, instr_rdata_intg_o, instr_rdata_o},
            {mem_err_i, mem_rdata_intg_i, mem_rdata_i});
        chk("data_resp", {data_err_o, data_rdata_intg_o, data_rdata_o},
            {mem_err_i, mem_rdata_intg_i, mem_rdata_i});
        if (e_req) begin
            chk("mem_cmd", {mem_we_o, mem_be_o, mem_addr_o},
                (e_sel == 1) ? {data_we_i, data_be_i, data_addr_i}
                             : {1'b0, 4'hF, instr_addr_i});
            chk("mem_wdata", {mem_wdata_intg_o, mem_wdata_o},
                (e_sel == 1) ? {data_wdata_intg_i, data_wdata_i} : 39'h0);
        end
        if (e_ig || e_dg)
            $display("t=%0t grant port=%s addr=%08h outstanding=%0d", $time,
                     e_dg ? "data" : "instr", mem_addr_o, idq.size());
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        instr_req_i = 1'b0; data_req_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        instr_addr_i = 32'h0000_1000; data_addr_i = 32'h0000_2000;
        data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hDEAD_BEEF;
        data_wdata_intg_i = 7'h55; mem_rdata_i = 32'h0; mem_rdata_intg_i = 7'h0;
        mem_err_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Step 1: both ports request from reset, the memory grants every
        // cycle, and the response follows one cycle after the grant.
        do_reset();
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid_i = (idq.size() > 0);
            mem_rdata_i  = 32'h100 + i;
            cycle();
        end

        // Step 2: instr is held through three wait cycles, and data arrives
        // meanwhile but must wait its turn.
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_1000;
        cycle();
        data_req_i = 1'b1; data_addr_i = 32'h0000_2000;
        cycle();
        cycle();
        mem_gnt_i = 1'b1;
        cycle();
        instr_req_i = 1'b0;
        cycle();
        data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        cycle();
        cycle();
        mem_rvalid_i = 1'b0;

        // Step 3: the outstanding limit blocks a third request until one
        // response has returned.
        do_reset();
        data_req_i = 1'b1; mem_gnt_i = 1'b1;
        cycle();
        cycle();
        cycle();
        mem_rvalid_i = 1'b1;
        cycle();
        mem_rvalid_i = 1'b0;
        cycle();
        data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        cycle();
        cycle();
        mem_rvalid_i = 1'b0;

        // Step 4: grants instr, data, instr return responses 0xA, 0xB, 0xC.
        do_reset();
        mem_gnt_i = 1'b1; instr_req_i = 1'b1;
        cycle();
        instr_req_i = 1'b0; data_req_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA;
        cycle();
        data_req_i = 1'b0; instr_req_i = 1'b1; mem_rdata_i = 32'hB;
        cycle();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'hC;
        cycle();
        mem_rvalid_i = 1'b0;

        // Step 5: a stray rvalid with nothing outstanding sets the sticky flag.
        mem_rvalid_i = 1'b1;
        cycle();
        mem_rvalid_i = 1'b0;
        cycle();
        cycle();

        // Step 6: reset while LOCKED with one transaction outstanding, then a
        // stray rvalid.
        do_reset();
        data_req_i = 1'b1; mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0; instr_req_i = 1'b1;
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0; clear_inputs();
        cycle();
        mem_rvalid_i = 1'b1;
        cycle();
        mem_rvalid_i = 1'b0;
        cycle();

        // Step 7: randomized traffic. Requesters hold their address until
        // granted, and the memory has random grant and response timing.
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            rst_i = ($urandom_range(99) == 0);
            if (!instr_req_i || e_ig) begin
                instr_req_i  = ($urandom_range(2) != 0);
                instr_addr_i = $urandom;
            end
            if (!data_req_i || e_dg) begin
                data_req_i        = ($urandom_range(2) != 0);
                data_we_i         = 1'($urandom);
                data_be_i         = 4'($urandom);
                data_addr_i       = $urandom;
                data_wdata_i      = $urandom;
                data_wdata_intg_i = 7'($urandom);
            end
            mem_gnt_i        = ($urandom_range(3) != 0);
            mem_rvalid_i     = ((idq.size() > 0) && ($urandom_range(1) == 1)) ||
                               ($urandom_range(63) == 0);
            mem_rdata_i      = $urandom;
            mem_rdata_intg_i = 7'($urandom);
            mem_err_i        = 1'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
